// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver with mid-bit sampling, a one-deep valid/ready
//               output register and framing/overrun/parity error pulses.
//               Optional parity bit enabled by macro UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_full_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] c_bit_last  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_fall;
    logic                 w_cnt_clr;
    logic                 w_shift;
    logic                 w_done;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
    logic                 w_par_take;
    logic                 w_par_bad;
`endif

    // Two-flop synchroniser; idle-high reset so no edge is seen out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_take   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (w_fall) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = r_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == c_full_last) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt == c_full_last) begin
                    w_cnt_clr    = 1'b1;
                    w_par_take   = 1'b1;
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be caught
                if (r_cnt == c_full_last) begin
                    w_cnt_clr    = 1'b1;
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = ((^r_shift) ^ r_par_bit) != PARITY_ODD;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);

            if (r_state == ST_START) begin
                r_bit <= '0;
            end else if (w_shift) begin
                r_bit <= r_bit + BIT_W'(1);
            end

            if (w_shift) begin
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            end

            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
            if (w_par_take) begin
                r_par_bit <= r_rx_s;
            end
`endif

            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            // A load in the accept cycle overrides the clear above
            if (w_done) begin
                if (!r_rx_s) begin
                    frame_err <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                else if (w_par_bad) begin
                    parity_err <= 1'b1;
                end
`endif
                else if (m_valid && !m_ready) begin
                    overrun_err <= 1'b1;
                end else begin
                    m_data  <= r_shift;
                    m_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
